// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the 32-bit ripple ALU bit slices.
//   - ALU_* : 3-bit opcodes {Op2,Op1,Op0}
//   - SEL_* : 2-bit result-select codes {Op1,Op0}
//   - slice_out_t : bundled slice outputs {ri, cout, set, vout}
//   - maj3() : majority function used for the adder carry-out
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef struct packed {
    logic ri;
    logic cout;
    logic set;
    logic vout;
  } slice_out_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_1b.sv
// ----------------------------------------------------------------------------
// full_adder_1b
//   One-bit full adder shared by every ALU bit slice.
//   Ports: a, b, cin (inputs); sum, cout (outputs). Purely combinational.
// ----------------------------------------------------------------------------
module full_adder_1b
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/msb.sv
// ----------------------------------------------------------------------------
// msb
//   Most-significant-bit slice (bit 31) of the 32-bit ripple ALU. Performs the
//   same AND/OR/ADD/SLT function as an ordinary slice and additionally
//   produces Set (routed to bit-0 Less for SLT) and Vout (signed overflow).
//
//   Parameter REG_OUT: 1 = outputs registered (1-cycle latency, async reset);
//                      0 = outputs combinational, clk/rst_n unused.
//   Optional macro SLT_OVF_CORRECT_EN: when defined, Set = sum ^ Vout so SLT
//   stays correct when the subtraction overflows; otherwise Set = sum.
//
//   Ports:
//     clk, rst_n      clock (rising edge), asynchronous active-low reset
//     Ai, Bi          operand bits 31
//     Cin             carry in from bit 30
//     Less            SLT input (tied 0 at the MSB in the top level)
//     Op2             B invert
//     Op1, Op0        result select
//     Ri              result bit 31
//     Cout            adder carry out
//     Set             signed less-than flag
//     Vout            signed overflow
// ----------------------------------------------------------------------------
module msb
  import alu_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Ai,
  input  logic Bi,
  input  logic Cin,
  input  logic Less,
  input  logic Op2,
  input  logic Op1,
  input  logic Op0,
  output logic Ri,
  output logic Cout,
  output logic Set,
  output logic Vout
);

  logic       b_inv;
  logic       sum;
  logic       carry;
  slice_out_t out_d;
  slice_out_t out_res;

  // B is inverted ahead of both the logic functions and the adder, which is
  // what turns ADD into SUB and AND/OR into A&~B / A|~B.
  assign b_inv = Bi ^ Op2;

  full_adder_1b u_fa (
    .a    (Ai),
    .b    (b_inv),
    .cin  (Cin),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    out_d = '0;
    unique case ({Op1, Op0})
      SEL_AND:  out_d.ri = Ai & b_inv;
      SEL_OR:   out_d.ri = Ai | b_inv;
      SEL_SUM:  out_d.ri = sum;
      SEL_LESS: out_d.ri = Less;
      default:  out_d.ri = 1'bx;
    endcase
    out_d.cout = carry;
    // Signed overflow at the MSB: carry into the sign bit differs from carry out.
    out_d.vout = Cin ^ carry;
`ifdef SLT_OVF_CORRECT_EN
    // On overflow the sign bit of the difference is inverted, so flip it back.
    out_d.set = sum ^ out_d.vout;
`else
    out_d.set = sum;
`endif
  end

  if (REG_OUT) begin : g_reg
    slice_out_t out_q;

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs at the same edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign out_res = out_q;
  end else begin : g_comb
    assign out_res = out_d;
  end

  assign Ri   = out_res.ri;
  assign Cout = out_res.cout;
  assign Set  = out_res.set;
  assign Vout = out_res.vout;

endmodule

// File: tb/tb_msb.sv
// ----------------------------------------------------------------------------
// tb_msb
//   Self-checking bench for msb. A registered instance (REG_OUT=1) and a
//   combinational instance (REG_OUT=0) see identical inputs. Each applied
//   vector pushes its expected {Ri,Cout,Set,Vout} into a scoreboard queue; a
//   monitor pops one entry per clock and compares both instances.
//   Expected values follow SLT_OVF_CORRECT_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_msb;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ai, bi, cin, less, op2, op1, op0;
  logic r_ri, r_cout, r_set, r_vout;
  logic c_ri, c_cout, c_set, c_vout;

  always #5 clk = ~clk;

  msb #(.REG_OUT(1'b1)) u_reg (
    .clk (clk), .rst_n (rst_n),
    .Ai (ai), .Bi (bi), .Cin (cin), .Less (less),
    .Op2 (op2), .Op1 (op1), .Op0 (op0),
    .Ri (r_ri), .Cout (r_cout), .Set (r_set), .Vout (r_vout)
  );

  msb #(.REG_OUT(1'b0)) u_comb (
    .clk (clk), .rst_n (rst_n),
    .Ai (ai), .Bi (bi), .Cin (cin), .Less (less),
    .Op2 (op2), .Op1 (op1), .Op0 (op0),
    .Ri (c_ri), .Cout (c_cout), .Set (c_set), .Vout (c_vout)
  );

  typedef struct {
    string      name;
    logic [6:0] vec;   // {Ai,Bi,Cin,Less,Op2,Op1,Op0}
    logic [3:0] exp;   // {Ri,Cout,Set,Vout}
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

`ifdef SLT_OVF_CORRECT_EN
  localparam logic OVF_SET = 1'b0;
`else
  localparam logic OVF_SET = 1'b1;
`endif

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {Ri,Cout,Set,Vout}=%b expected %b", name, act, exp);
    end
  endtask

  // Reference model built from integer addition and signed interpretation.
  function automatic logic [3:0] model(input logic [6:0] v);
    logic       a, b, c, l;
    logic [1:0] s2;
    logic       r, ov, st;
    a  = v[6];
    b  = v[5] ^ v[2];
    c  = v[4];
    l  = v[3];
    s2 = {1'b0, a} + {1'b0, b} + {1'b0, c};
    // Overflow when both sign inputs agree and the result sign differs.
    ov = (a == b) && (s2[0] != a);
`ifdef SLT_OVF_CORRECT_EN
    st = ov ? ~s2[0] : s2[0];
`else
    st = s2[0];
`endif
    case (v[1:0])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = s2[0];
      default: r = l;
    endcase
    return {r, s2[1], st, ov};
  endfunction

  task automatic apply(input string name, input logic [6:0] v, input logic [3:0] exp);
    sb_item_t it;
    @(negedge clk);
    {ai, bi, cin, less, op2, op1, op0} = v;
    it.name = name;
    it.vec  = v;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  // Monitor: one result per clock while the scoreboard holds entries.
  initial begin : monitor
    sb_item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && sb.size() > 0) begin
        it = sb.pop_front();
        check($sformatf("%s reg vec=%b", it.name, it.vec), {r_ri, r_cout, r_set, r_vout}, it.exp);
        check($sformatf("%s comb vec=%b", it.name, it.vec), {c_ri, c_cout, c_set, c_vout}, it.exp);
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    rst_n = 1'b0;
    {ai, bi, cin, less, op2, op1, op0} = '0;
    #2;
    check("reset_state", {r_ri, r_cout, r_set, r_vout}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Ai=0 Bi=1 Less=0, Cin=0 across the used opcodes.
    apply("t1_and", {3'b010, 1'b0, ALU_AND}, 4'b0010);
    apply("t1_or",  {3'b010, 1'b0, ALU_OR},  4'b1010);
    apply("t1_add", {3'b010, 1'b0, ALU_ADD}, 4'b1010);
    apply("t1_sub", {3'b010, 1'b0, ALU_SUB}, 4'b0000);
    apply("t1_slt", {3'b010, 1'b0, ALU_SLT}, 4'b0000);
    // Cin=1.
    apply("t2_and", {3'b011, 1'b0, ALU_AND}, 4'b0100);
    apply("t2_or",  {3'b011, 1'b0, ALU_OR},  4'b1100);
    apply("t2_add", {3'b011, 1'b0, ALU_ADD}, 4'b0100);
    // Overflowing subtraction.
    apply("t3_sub", {3'b011, 1'b0, ALU_SUB}, {3'b100, 1'b1} | {2'b00, OVF_SET, 1'b0});
    apply("t3_slt", {3'b011, 1'b0, ALU_SLT}, {3'b000, 1'b1} | {2'b00, OVF_SET, 1'b0});
    // Op 011 selects Less.
    apply("t4_less", {3'b100, 1'b1, 3'b011}, 4'b1010);

    // Async reset between edges with nonzero outputs loaded.
    @(posedge clk);
    #3;
    check("t5_loaded", {r_ri, r_cout, r_set, r_vout}, 4'b1010);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {r_ri, r_cout, r_set, r_vout}, 4'b0000);
    check("t5_comb_unaffected", {c_ri, c_cout, c_set, c_vout}, 4'b1010);
    repeat (2) @(posedge clk);
    #1;
    check("t5_hold", {r_ri, r_cout, r_set, r_vout}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep against the reference model.
    for (int i = 0; i < 128; i++) begin
      logic [6:0] v;
      v = 7'(i);
      apply("sweep", v, model(v));
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
